seq_div: RTL and testbench

//  Sequential restoring divider, inverse of the seq_mult datapath: divides 16-bit dataa by 8-bit datab,
//  one quotient bit per clock. start/done_flag handshake matches seq_mult, so the same top-level

---
 rtl/seq_arith_pkg.sv | 18 +
 rtl/seq_state_7seg.sv | 22 ++
 rtl/seq_div.sv | 108 ++++++++++
 tb/tb_seq_div.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (seq_div, seq_mult):
// FSM state codes and the seven-segment glyphs used to display them.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_E = 7'b1111001;

endpackage : seq_arith_pkg

// File: rtl/seq_state_7seg.sv
// Combinational decoder from the 2-bit FSM state code to a single
// seven-segment digit for board bring-up.
module seq_state_7seg
  import seq_arith_pkg::*;
(
  input  state_t     state,
  output logic [6:0] seg
);

  // Map each state to its display glyph
  always_comb begin
    seg = SEG_0;
    case (state)
      S_IDLE:  seg = SEG_0;
      S_CALC:  seg = SEG_1;
      S_DONE:  seg = SEG_2;
      S_ERR:   seg = SEG_E;
      default: seg = SEG_0;
    endcase
  end

endmodule : seq_state_7seg

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done_flag
// handshake, zero-divisor trap, and a state digit on seven_seg.
module seq_div
  import seq_arith_pkg::*;
#(
  parameter int DVD_W = 16,
  parameter int DVR_W = 8
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic [DVD_W-1:0] dataa,
  input  logic [DVR_W-1:0] datab,
  input  logic             start,
  output logic [DVD_W-1:0] quotient_out,
  output logic [DVR_W-1:0] remainder_out,
  output logic             done_flag,
  output logic             div_by_zero,
  output logic [6:0]       seven_seg
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [DVD_W-1:0] q_r;
  logic [DVR_W-1:0] r_r;
  logic [DVR_W-1:0] d_r;

  logic [DVR_W:0]   t_s;
  logic             ge_s;
  logic [DVR_W-1:0] r_next_s;
  logic [DVD_W-1:0] q_next_s;

  // One restoring step: shift the next dividend bit into the partial remainder
  // (one bit wider than the divisor so the compare cannot overflow), subtract if it fits
  always_comb begin
    t_s      = {r_r, q_r[DVD_W-1]};
    ge_s     = (t_s >= {1'b0, d_r});
    q_next_s = {q_r[DVD_W-2:0], ge_s};
    if (ge_s) begin
      r_next_s = DVR_W'(t_s - {1'b0, d_r});
    end else begin
      r_next_s = t_s[DVR_W-1:0];
    end
  end

  // Control FSM, iteration registers and registered result ports
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_r       <= S_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      q_r           <= {DVD_W{1'b0}};
      r_r           <= {DVR_W{1'b0}};
      d_r           <= {DVR_W{1'b0}};
      quotient_out  <= {DVD_W{1'b0}};
      remainder_out <= {DVR_W{1'b0}};
      done_flag     <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (datab == {DVR_W{1'b0}}) begin
              state_r       <= S_ERR;
              quotient_out  <= {DVD_W{1'b1}};
              remainder_out <= {DVR_W{1'b0}};
              done_flag     <= 1'b1;
              div_by_zero   <= 1'b1;
            end else begin
              state_r     <= S_CALC;
              q_r         <= dataa;
              d_r         <= datab;
              r_r         <= {DVR_W{1'b0}};
              cnt_r       <= CNT_W'(DVD_W);
              done_flag   <= 1'b0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        S_CALC: begin
          // start is deliberately ignored here: operands stay as latched
          q_r   <= q_next_s;
          r_r   <= r_next_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r       <= S_DONE;
            quotient_out  <= q_next_s;
            remainder_out <= r_next_s;
            done_flag     <= 1'b1;
          end else begin
            state_r <= S_CALC;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  seq_state_7seg u_seg (
    .state (state_r),
    .seg   (seven_seg)
  );

endmodule : seq_div

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed vector table, hand-written
// corner sequences, and random operands checked against integer / and %.
module tb_seq_div;
  import seq_arith_pkg::*;

  logic        clk;
  logic        reset_a;
  logic [15:0] dataa;
  logic [7:0]  datab;
  logic        start;
  logic [15:0] quotient_out;
  logic [7:0]  remainder_out;
  logic        done_flag;
  logic        div_by_zero;
  logic [6:0]  seven_seg;

  int n_chk  = 0;
  int n_pass = 0;

  seq_div dut (
    .clk           (clk),
    .reset_a       (reset_a),
    .dataa         (dataa),
    .datab         (datab),
    .start         (start),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .done_flag     (done_flag),
    .div_by_zero   (div_by_zero),
    .seven_seg     (seven_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Run one division; optionally pulse start with other operands at CALC cycle inj_at.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] exp_q, input logic [7:0] exp_r, input logic exp_dz,
                         input int inj_at, input logic [15:0] inj_a, input logic [7:0] inj_b);
    int lat;
    lat = 0;
    @(negedge clk);
    dataa = a; datab = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (b != 8'd0) begin
      check("done_low_in_calc", {31'd0, done_flag}, 32'd0);
      check("dz_low_in_calc", {31'd0, div_by_zero}, 32'd0);
      check("seg_calc", {25'd0, seven_seg}, {25'd0, SEG_1});
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(negedge clk);
        if (cyc == inj_at) begin
          dataa = inj_a; datab = inj_b; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        if (done_flag) begin
          lat = cyc;
          break;
        end
      end
      start = 1'b0;
      check("latency", lat, 32'd16);
    end
    check("done_flag", {31'd0, done_flag}, 32'd1);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dz});
    check("quotient", {16'd0, quotient_out}, {16'd0, exp_q});
    check("remainder", {24'd0, remainder_out}, {24'd0, exp_r});
    check("seg_result", {25'd0, seven_seg}, {25'd0, (exp_dz ? SEG_E : SEG_2)});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] hq;
    logic [7:0]  hr;

    vecs[0] = '{a: 16'd1100,  b: 8'd10,  q: 16'd110,   r: 8'd0,  dz: 1'b0};
    vecs[1] = '{a: 16'hFFFF,  b: 8'hFF,  q: 16'h0101,  r: 8'd0,  dz: 1'b0};
    vecs[2] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,  dz: 1'b0};
    vecs[3] = '{a: 16'd5,     b: 8'd10,  q: 16'd0,     r: 8'd5,  dz: 1'b0};
    vecs[4] = '{a: 16'd1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'd0,  dz: 1'b1};
    vecs[5] = '{a: 16'd300,   b: 8'd255, q: 16'd1,     r: 8'd45, dz: 1'b0};
    vecs[6] = '{a: 16'd0,     b: 8'd1,   q: 16'd0,     r: 8'd0,  dz: 1'b0};
    vecs[7] = '{a: 16'hFFFF,  b: 8'd1,   q: 16'hFFFF,  r: 8'd0,  dz: 1'b0};
    vecs[8] = '{a: 16'd0,     b: 8'd0,   q: 16'hFFFF,  r: 8'd0,  dz: 1'b1};
    vecs[9] = '{a: 16'd65534, b: 8'd200, q: 16'd327,   r: 8'd134, dz: 1'b0};

    reset_a = 1'b0; dataa = 16'd0; datab = 8'd0; start = 1'b0;
    #12;
    check("rst_quotient", {16'd0, quotient_out}, 32'd0);
    check("rst_remainder", {24'd0, remainder_out}, 32'd0);
    check("rst_done", {31'd0, done_flag}, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    check("rst_seg", {25'd0, seven_seg}, {25'd0, SEG_0});
    reset_a = 1'b1;
    @(posedge clk); #1;
    check("idle_seg", {25'd0, seven_seg}, {25'd0, SEG_0});

    for (int i = 0; i < 10; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, -1, 16'd0, 8'd0);

    // Result held in DONE while start stays low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_done", {31'd0, done_flag}, 32'd1);
      check("hold_quotient", {16'd0, quotient_out}, {16'd0, vecs[9].q});
    end

    // start during CALC is ignored
    run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 5, 16'd999, 8'd3);

    // Async reset mid-CALC, then a fresh division
    @(negedge clk);
    dataa = 16'd1000; datab = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset_a = 1'b0;
    #1;
    check("abort_quotient", {16'd0, quotient_out}, 32'd0);
    check("abort_remainder", {24'd0, remainder_out}, 32'd0);
    check("abort_done", {31'd0, done_flag}, 32'd0);
    check("abort_seg", {25'd0, seven_seg}, {25'd0, SEG_0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b1;
    run_div(16'd4321, 8'd13, 16'd332, 8'd5, 1'b0, -1, 16'd0, 8'd0);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(255, 1));
      if (rb == 8'd0) begin
        hq = 16'hFFFF; hr = 8'd0;
      end else begin
        hq = ra / {8'd0, rb};
        hr = 8'(ra % {8'd0, rb});
      end
      run_div(ra, rb, hq, hr, (rb == 8'd0), -1, 16'd0, 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_seq_div
